nf_wb_ctrl: RTL and testbench

- Write-back controller that owns the single register-file write port (wa3/wd3/we3).
- Merges ALU results with load data, which returns later from the LSU.
- Holds an in-order queue of outstanding loads, sign/zero-extends and aligns the returned data, and keeps a per-register pending scoreboard.
- The scoreboard drives a decode stall, so no instruction reads a register whose load has not yet been written.

---
 rtl/nf_wb_ctrl.sv | 178 +++++++++++++++++
 tb/tb_nf_wb_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/nf_wb_ctrl.sv
// Write-back controller: owns the register-file write port, queues outstanding loads,
// extends returned load data and keeps a per-register pending scoreboard. Option: NF_WB_BYPASS_EN.
module nf_wb_ctrl #(
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_we,
  input  logic [4:0]  alu_wa,
  input  logic [31:0] alu_wd,
  input  logic        ld_req,
  input  logic [4:0]  ld_wa,
  input  logic [1:0]  ld_size,
  input  logic        ld_sign,
  input  logic [1:0]  ld_addr_lo,
  output logic        ld_ack,
  input  logic        ld_rvalid,
  input  logic [31:0] ld_rdata,
  output logic        ld_rready,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  rd_chk,
`ifdef NF_WB_BYPASS_EN
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic [31:0] fwd_rd1,
  output logic [31:0] fwd_rd2,
`endif
  output logic        stall,
  output logic        ld_err,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        we3
);

  localparam int unsigned PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CW = $clog2(LQ_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(LQ_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] size;
    logic       sign;
    logic [1:0] lo;
  } lq_entry_t;

  lq_entry_t     lq [LQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          lq_full;
  logic          lq_empty;
  lq_entry_t     head;

  logic          stg_valid;
  logic [4:0]    stg_wa;
  logic [31:0]   stg_wd;
  logic          stg_drain;

  logic [31:0]   pending;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;
  logic [31:0]   hold;
  logic          wb_ld;

  logic          push;
  logic          pop;
  logic [31:0]   ext_data;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                         input logic sign, input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (size)
      2'd0:    r = {{24{sign & b[7]}}, b};
      2'd1:    r = {{16{sign & h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign lq_full   = (count == FULL_CNT);
  assign lq_empty  = (count == '0);
  assign head      = lq[rd_ptr];
  assign ext_data  = extend(ld_rdata, head.size, head.sign, head.lo);

  assign stg_drain = stg_valid & ~alu_we;
  assign ld_rready = ~stg_valid | stg_drain;
  assign ld_ack    = ld_req & ~lq_full & ~pending[ld_wa];
  assign push      = ld_ack;
  assign pop       = ld_rvalid & ld_rready & ~lq_empty;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (push && (ld_wa != '0)) set_mask[ld_wa] = 1'b1;
    // a load's pending bit is released by the cycle that presents its we3
    if (we3 && wb_ld) clr_mask[wa3] = 1'b1;
  end

`ifdef NF_WB_BYPASS_EN
  assign hold    = pending & ~clr_mask;
  assign fwd_rd1 = (we3 && (wa3 == ra1) && (ra1 != '0)) ? wd3 : rf_rd1;
  assign fwd_rd2 = (we3 && (wa3 == ra2) && (ra2 != '0)) ? wd3 : rf_rd2;
`else
  assign hold    = pending;
`endif

  assign stall = ((ra1    != '0) & hold[ra1]) |
                 ((ra2    != '0) & hold[ra2]) |
                 ((rd_chk != '0) & hold[rd_chk]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stg_valid <= 1'b0;
      stg_wa    <= '0;
      stg_wd    <= '0;
      pending   <= '0;
      wb_ld     <= 1'b0;
      wa3       <= '0;
      wd3       <= '0;
      we3       <= 1'b0;
      ld_err    <= 1'b0;
    end else begin
      if (push) begin
        lq[wr_ptr] <= '{wa: ld_wa, size: ld_size, sign: ld_sign, lo: ld_addr_lo};
        wr_ptr     <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (ld_rvalid && lq_empty) ld_err <= 1'b1;

      // a pop in a draining cycle refills staging directly
      if (pop) begin
        stg_valid <= 1'b1;
        stg_wa    <= head.wa;
        stg_wd    <= ext_data;
      end else if (stg_drain) begin
        stg_valid <= 1'b0;
      end

      if (alu_we) begin
        wa3   <= alu_wa;
        wd3   <= alu_wd;
        we3   <= (alu_wa != '0);
        wb_ld <= 1'b0;
      end else if (stg_valid) begin
        wa3   <= stg_wa;
        wd3   <= stg_wd;
        we3   <= (stg_wa != '0);
        wb_ld <= (stg_wa != '0);
      end else begin
        we3   <= 1'b0;
        wb_ld <= 1'b0;
      end

      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_nf_wb_ctrl.sv
// Directed vector bench for nf_wb_ctrl (default LQ_DEPTH=2), with NF_WB_BYPASS_EN-aware expectations.
module tb_nf_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        ld_req;
  logic [4:0]  ld_wa;
  logic [1:0]  ld_size;
  logic        ld_sign;
  logic [1:0]  ld_addr_lo;
  logic        ld_ack;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        ld_rready;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  rd_chk;
  logic        stall;
  logic        ld_err;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        we3;
`ifdef NF_WB_BYPASS_EN
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic [31:0] fwd_rd1;
  logic [31:0] fwd_rd2;
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  nf_wb_ctrl #(.LQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .ld_req(ld_req), .ld_wa(ld_wa), .ld_size(ld_size), .ld_sign(ld_sign),
    .ld_addr_lo(ld_addr_lo), .ld_ack(ld_ack),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_rready(ld_rready),
    .ra1(ra1), .ra2(ra2), .rd_chk(rd_chk),
`ifdef NF_WB_BYPASS_EN
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2),
`endif
    .stall(stall), .ld_err(ld_err),
    .wa3(wa3), .wd3(wd3), .we3(we3)
  );

  typedef struct {
    logic        rst, aw;
    logic [4:0]  awa;
    logic [31:0] awd;
    logic        lr;
    logic [4:0]  lwa;
    logic [1:0]  sz;
    logic        sg;
    logic [1:0]  lo;
    logic        rv;
    logic [31:0] rd;
    logic [4:0]  r1, r2, rc;
    logic        cc, ack, rrdy, stl;
    logic        we, cd;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        err;
  } vec_t;

  vec_t vt[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic vec_t mk(
      input logic rst_i, input logic aw, input logic [4:0] awa, input logic [31:0] awd,
      input logic lr, input logic [4:0] lwa, input logic [1:0] sz, input logic sg, input logic [1:0] lo,
      input logic rv, input logic [31:0] rd, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rc,
      input logic cc, input logic ack, input logic rrdy, input logic stl,
      input logic we, input logic cd, input logic [4:0] wa, input logic [31:0] wd, input logic err);
    vec_t v;
    v.rst = rst_i; v.aw = aw; v.awa = awa; v.awd = awd;
    v.lr = lr; v.lwa = lwa; v.sz = sz; v.sg = sg; v.lo = lo;
    v.rv = rv; v.rd = rd; v.r1 = r1; v.r2 = r2; v.rc = rc;
    v.cc = cc; v.ack = ack; v.rrdy = rrdy; v.stl = stl;
    v.we = we; v.cd = cd; v.wa = wa; v.wd = wd; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic zero_in();
    rst = 1'b0; alu_we = 1'b0; alu_wa = '0; alu_wd = '0;
    ld_req = 1'b0; ld_wa = '0; ld_size = '0; ld_sign = 1'b0; ld_addr_lo = '0;
    ld_rvalid = 1'b0; ld_rdata = '0; ra1 = '0; ra2 = '0; rd_chk = '0;
`ifdef NF_WB_BYPASS_EN
    rf_rd1 = '0; rf_rd2 = '0;
`endif
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; alu_we = v.aw; alu_wa = v.awa; alu_wd = v.awd;
    ld_req = v.lr; ld_wa = v.lwa; ld_size = v.sz; ld_sign = v.sg; ld_addr_lo = v.lo;
    ld_rvalid = v.rv; ld_rdata = v.rd; ra1 = v.r1; ra2 = v.r2; rd_chk = v.rc;
  endtask

  initial begin
    zero_in();
    // rst aw awa awd | lr lwa sz sg lo | rv rd | ra1 ra2 rdc | cc ack rrdy stall | we cd wa3 wd3 | err
    vt.push_back(mk(1,0,0,0,            0,0,0,0,0, 1,0,             0,0,0,  0,0,0,0,    0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,            0,0,0,0,0, 1,0,             0,0,0,  1,0,1,0,    0,1,0,0,0));
    vt.push_back(mk(0,1,5,'h1234,       0,0,0,0,0, 0,0,             0,0,0,  1,0,1,0,    1,1,5,'h1234,0));
    vt.push_back(mk(0,1,0,'hDEAD,       0,0,0,0,0, 0,0,             0,0,0,  1,0,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            1,7,0,1,2, 0,0,             0,0,0,  1,1,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             7,0,0,  1,0,1,1,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 1,'h00800000,    7,0,0,  1,0,1,1,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             7,0,0,  1,0,1,1,    1,1,7,'hFFFFFF80,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             7,0,0,  1,0,1,!BYP, 0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             7,0,0,  1,0,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            1,4,2,0,0, 0,0,             0,0,0,  1,1,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            1,10,2,0,0,0,0,             0,0,0,  1,1,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,1,3,'h33,         0,0,0,0,0, 1,'hCAFEF00D,    0,0,0,  1,0,1,0,    1,1,3,'h33,0));
    vt.push_back(mk(0,1,3,'h34,         0,0,0,0,0, 1,'h11111111,    0,0,0,  1,0,0,0,    1,1,3,'h34,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             0,0,0,  1,0,1,0,    1,1,4,'hCAFEF00D,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 1,'hAB,          0,0,0,  1,0,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             0,0,0,  1,0,1,0,    1,1,10,'hAB,0));
    vt.push_back(mk(0,0,0,0,            1,8,2,0,0, 0,0,             0,0,0,  1,1,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            1,9,2,0,0, 0,0,             0,0,0,  1,1,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            1,10,2,0,0,0,0,             0,0,0,  1,0,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            1,10,2,0,0,1,'h12345678,    0,0,0,  1,0,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            1,9,2,0,0, 0,0,             0,0,0,  1,0,1,0,    1,1,8,'h12345678,0));
    vt.push_back(mk(0,0,0,0,            1,10,2,0,0,0,0,             0,0,0,  1,1,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 1,'hFFFFFFFF,    0,0,0,  1,0,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 1,'hABCD,        0,0,0,  1,0,1,0,    1,1,9,'hFFFFFFFF,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             0,0,0,  1,0,1,0,    1,1,10,'hABCD,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 1,'h5,           0,0,0,  1,0,1,0,    0,0,0,0,1));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             0,0,0,  1,0,1,0,    0,0,0,0,1));
    vt.push_back(mk(1,0,0,0,            0,0,0,0,0, 0,0,             0,0,0,  1,0,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            1,6,1,0,2, 0,0,             0,0,0,  1,1,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 1,'hBEEF0000,    0,6,0,  1,0,1,1,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             0,6,0,  1,0,1,1,    1,1,6,'h0000BEEF,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             0,6,0,  1,0,1,!BYP, 0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             0,6,0,  1,0,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            1,12,1,1,0,0,0,             0,0,0,  1,1,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            1,13,0,0,3,0,0,             0,0,0,  1,1,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 1,'h00008001,    0,0,0,  1,0,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 1,'hA5000000,    0,0,0,  1,0,1,0,    1,1,12,'hFFFF8001,0));
    vt.push_back(mk(0,0,0,0,            1,14,3,1,1,0,0,             0,0,0,  1,1,1,0,    1,1,13,'h000000A5,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 1,'h80000001,    0,0,0,  1,0,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             0,0,14, 1,0,1,1,    1,1,14,'h80000001,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             0,0,14, 1,0,1,!BYP, 0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            1,0,2,0,0, 0,0,             0,0,0,  1,1,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 1,'h77,          0,0,0,  1,0,1,0,    0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,0,             0,0,0,  1,0,1,0,    0,0,0,0,0));

    @(posedge clk); #1;
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      #1;
      if (vt[i].cc) begin
        chk($sformatf("v%0d_ack", i), ld_ack, vt[i].ack);
        chk($sformatf("v%0d_rready", i), ld_rready, vt[i].rrdy);
        chk($sformatf("v%0d_stall", i), stall, vt[i].stl);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_we3", i), we3, vt[i].we);
      chk($sformatf("v%0d_ld_err", i), ld_err, vt[i].err);
      if (vt[i].cd) begin
        chk($sformatf("v%0d_wa3", i), wa3, vt[i].wa);
        chk($sformatf("v%0d_wd3", i), wd3, vt[i].wd);
      end
    end

    // push with an unsolicited response while empty: pop ignored, error set, load still queued
    zero_in(); rst = 1'b1;
    @(posedge clk); #1;
    zero_in();
    ld_req = 1'b1; ld_wa = 5'd20; ld_size = 2'd2; ld_rvalid = 1'b1; ld_rdata = 32'hBAD;
    #1 chk("pp_ack", ld_ack, 1);
    @(posedge clk); #1;
    chk("pp_err", ld_err, 1);
    zero_in(); ld_rvalid = 1'b1; ld_rdata = 32'h42; ra1 = 5'd20;
    #1 chk("pp_rready", ld_rready, 1);
    chk("pp_stall", stall, 1);
    @(posedge clk); #1;
    zero_in();
    for (int i = 0; i < 4; i++) begin
      if (we3) break;
      @(posedge clk); #1;
    end
    chk("pp_we3_timeout", we3, 1);
    chk("pp_wa3", wa3, 32'd20);
    chk("pp_wd3", wd3, 32'h42);

    // load-use in the we3 cycle: stall released and forwarded only with bypass
    zero_in(); rst = 1'b1;
    @(posedge clk); #1;
    zero_in();
    ld_req = 1'b1; ld_wa = 5'd6; ld_size = 2'd1; ld_sign = 1'b0; ld_addr_lo = 2'd2;
    #1 chk("bp_ack", ld_ack, 1);
    @(posedge clk); #1;
    zero_in(); ld_rvalid = 1'b1; ld_rdata = 32'hBEEF0000;
    @(posedge clk); #1;
    zero_in();
    @(posedge clk); #1;
    ra2 = 5'd6;
`ifdef NF_WB_BYPASS_EN
    rf_rd1 = 32'h11; rf_rd2 = 32'h12345678;
`endif
    #1;
    chk("bp_we3", we3, 1);
    chk("bp_stall", stall, !BYP);
`ifdef NF_WB_BYPASS_EN
    chk("bp_fwd_rd2", fwd_rd2, 32'h0000BEEF);
    chk("bp_fwd_rd1", fwd_rd1, 32'h11);
`endif
    @(posedge clk); #1;
    chk("bp_stall_after", stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
